// File: rtl/regdump_pkg.sv
// rtl/regdump_pkg.sv - shared types and constants for the register-file dump engine
package regdump_pkg;

  localparam int REGDUMP_IDX_W = 5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SEND = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4
  } regdump_state_t;

endpackage

// File: rtl/regfile_dump.sv
// rtl/regfile_dump.sv - walks the register file read port and streams every register out; REGDUMP_CHECKSUM_EN adds a trailing XOR checksum beat
module regfile_dump
  import regdump_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int DW    = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     wr_busy,
  output logic [REGDUMP_IDX_W-1:0] ra,
  input  logic [DW-1:0]            rd,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW-1:0]            out_data,
  output logic [REGDUMP_IDX_W-1:0] out_idx,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done
);

  localparam logic [REGDUMP_IDX_W-1:0] LAST_IDX = REGDUMP_IDX_W'(NREGS - 1);

  regdump_state_t             r_state;
  logic [REGDUMP_IDX_W-1:0]   r_idx;
  logic [DW-1:0]              r_data;
  logic [REGDUMP_IDX_W-1:0]   r_out_idx;
  logic                       r_valid;
  logic                       r_last;
  logic                       r_busy;
  logic                       r_done;
`ifdef REGDUMP_CHECKSUM_EN
  logic [DW-1:0]              r_acc;
`endif

  // The walk index doubles as the read address, so ra simply holds outside LOAD.
  assign ra        = r_idx;
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_idx   = r_out_idx;
  assign out_last  = r_last;
  assign busy      = r_busy;
  assign done      = r_done;

  // Dump sequencer: capture in LOAD (only when the core is not writing), hold the beat in SEND.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_data    <= '0;
      r_out_idx <= '0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
      r_acc     <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_last  <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            r_acc   <= '0;
`endif
            r_state <= LOAD;
          end
        end
        LOAD: begin
          // While the core writes, rd shows the bypassed write data, so wait it out.
          if (!wr_busy) begin
            r_data    <= rd;
            r_out_idx <= r_idx;
            r_valid   <= 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
            r_last    <= 1'b0;
            r_acc     <= r_acc ^ rd;
`else
            r_last    <= (r_idx == LAST_IDX);
`endif
            r_state   <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (r_idx == LAST_IDX) begin
`ifdef REGDUMP_CHECKSUM_EN
              // Checksum beat follows immediately; valid stays high across the switch.
              r_data    <= r_acc;
              r_out_idx <= '0;
              r_last    <= 1'b1;
              r_state   <= CSUM;
`else
              r_valid   <= 1'b0;
              r_last    <= 1'b0;
              r_done    <= 1'b1;
              r_state   <= DONE;
`endif
            end else begin
              r_valid <= 1'b0;
              r_idx   <= r_idx + 1'b1;
              r_state <= LOAD;
            end
          end
        end
`ifdef REGDUMP_CHECKSUM_EN
        CSUM: begin
          if (out_ready) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
`endif
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// tb/tb_regfile_dump.sv - randomized self-checking bench for regfile_dump against a queue-based model
module tb_regfile_dump;

  localparam int NREGS = 32;
  localparam int DW    = 64;
`ifdef REGDUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  localparam logic [DW-1:0] BYPASS_JUNK = 64'hB1A5_B1A5_B1A5_B1A5;

  logic          clk = 1'b0;
  logic          rst_n, start, wr_busy, out_ready;
  logic [4:0]    ra;
  logic [DW-1:0] rd;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [4:0]    out_idx;
  logic          out_last, busy, done;

  logic [DW-1:0] regs [0:NREGS-1];

  // Register-file read port: combinational, and shows bypass data while the core writes.
  assign rd = wr_busy ? BYPASS_JUNK : regs[ra];

  always #5 clk = ~clk;

  regfile_dump #(.NREGS(NREGS), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .wr_busy(wr_busy),
    .ra(ra), .rd(rd), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
    .busy(busy), .done(done)
  );

  int vectors    = 0;
  int miscompares = 0;
  int stab_err;

  logic [DW-1:0] q_data [$];
  logic [4:0]    q_idx  [$];
  logic          q_last [$];
  logic [DW-1:0] e_data [$];
  logic [4:0]    e_idx  [$];
  logic          e_last [$];

  // Reference model: every register in order, then optionally the XOR of all of them.
  task automatic build_expected(input int ov_idx, input logic [DW-1:0] ov_val);
    logic [DW-1:0] acc;
    logic [DW-1:0] v;
    acc = '0;
    e_data.delete(); e_idx.delete(); e_last.delete();
    for (int i = 0; i < NREGS; i++) begin
      v = (i == ov_idx) ? ov_val : regs[i];
      acc ^= v;
      e_data.push_back(v);
      e_idx.push_back(5'(i));
      e_last.push_back((i == NREGS - 1) && (CS == 0));
    end
    if (CS != 0) begin
      e_data.push_back(acc);
      e_idx.push_back(5'd0);
      e_last.push_back(1'b1);
    end
  endtask

  // Drives one dump and records accepted beats; ready_mode 0=always, 1=toggle, 2=random.
  task automatic run_dump(input int ready_mode, input int stall_idx, input int restart_beat,
                          input int reset_beat, output int done_cyc);
    int cyc;
    int stall_cnt;
    bit stalled;
    logic pv, pr, pl;
    logic [DW-1:0] pd;
    logic [4:0] pi;
    q_data.delete(); q_idx.delete(); q_last.delete();
    stab_err = 0; done_cyc = -1; stall_cnt = 0; stalled = 1'b0;
    pv = 1'b0; pr = 1'b0; pd = '0; pi = '0; pl = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    out_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    cyc = 0;
    while (cyc < 600) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (stall_cnt > 0) begin
        stall_cnt--;
        if (stall_cnt == 0) begin
          regs[stall_idx] = 64'hDEAD;
          wr_busy = 1'b0;
        end
      end else if (stall_idx >= 0 && !stalled && busy && !out_valid && ra == 5'(stall_idx)) begin
        wr_busy = 1'b1;
        stall_cnt = 3;
        stalled = 1'b1;
      end
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (pv && !pr && (!out_valid || out_data !== pd || out_idx !== pi || out_last !== pl))
        stab_err++;
      pv = out_valid; pr = out_ready; pd = out_data; pi = out_idx; pl = out_last;
      if (out_valid && out_ready) begin
        q_data.push_back(out_data);
        q_idx.push_back(out_idx);
        q_last.push_back(out_last);
        if (q_data.size() == restart_beat + 1) start = 1'b1;
        if (q_data.size() == reset_beat + 1) begin
          wr_busy = 1'b0;
          return;
        end
      end
    end
    start = 1'b0;
    wr_busy = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; wr_busy = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({ra, out_valid, out_data, out_idx, out_last, busy, done} !== '0) begin
      miscompares++;
      $display("FAIL reset_in: outputs=%h required 0", {ra, out_valid, out_data, out_idx, out_last, busy, done});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({ra, out_valid, out_data, out_idx, out_last, busy, done} !== '0) begin
      miscompares++;
      $display("FAIL reset_idle: outputs=%h required 0", {ra, out_valid, out_data, out_idx, out_last, busy, done});
    end
  endtask

  task automatic test_basic();
    int dc;
    for (int i = 0; i < NREGS; i++) regs[i] = DW'(i);
    regs[NREGS-1] = '0;
    build_expected(-1, '0);
    run_dump(0, -1, -1, -1, dc);
    vectors++;
    if (q_data.size() !== e_data.size()) begin
      miscompares++;
      $display("FAIL basic_count: got %0d beats required %0d", q_data.size(), e_data.size());
    end
    for (int i = 0; i < q_data.size() && i < e_data.size(); i++) begin
      vectors++;
      if (q_data[i] !== e_data[i] || q_idx[i] !== e_idx[i] || q_last[i] !== e_last[i]) begin
        miscompares++;
        $display("FAIL basic_beat%0d: got d=%h i=%0d l=%b required d=%h i=%0d l=%b",
                 i, q_data[i], q_idx[i], q_last[i], e_data[i], e_idx[i], e_last[i]);
      end
    end
    if (CS != 0 && q_data.size() == NREGS + 1) begin
      vectors++;
      if (q_data[NREGS] !== 64'h1F) begin
        miscompares++;
        $display("FAIL basic_csum: got %h required 1f", q_data[NREGS]);
      end
    end
    vectors++;
    if (dc !== 2 * NREGS + 1 + CS) begin
      miscompares++;
      $display("FAIL basic_done_cycle: got %0d required %0d", dc, 2 * NREGS + 1 + CS);
    end
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_after: busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_ready_toggle();
    int dc;
    for (int i = 0; i < NREGS; i++) regs[i] = {$urandom, $urandom};
    build_expected(-1, '0);
    run_dump(1, -1, -1, -1, dc);
    vectors++;
    if (stab_err !== 0) begin
      miscompares++;
      $display("FAIL toggle_stable: %0d unstable stalled beats required 0", stab_err);
    end
    vectors++;
    if (q_data !== e_data || q_idx !== e_idx || q_last !== e_last || dc < 0) begin
      miscompares++;
      $display("FAIL toggle_seq: beats=%0d done_cycle=%0d required %0d beats", q_data.size(), dc, e_data.size());
    end
  endtask

  task automatic test_random();
    int dc;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NREGS; i++) regs[i] = {$urandom, $urandom};
      build_expected(-1, '0);
      run_dump(2, -1, -1, -1, dc);
      vectors++;
      if (stab_err !== 0) begin
        miscompares++;
        $display("FAIL random_stable%0d: %0d unstable stalled beats required 0", r, stab_err);
      end
      vectors++;
      if (q_data !== e_data || q_idx !== e_idx || q_last !== e_last || dc < 0) begin
        miscompares++;
        $display("FAIL random_seq%0d: beats=%0d done_cycle=%0d required %0d beats", r, q_data.size(), dc, e_data.size());
      end
    end
  endtask

  task automatic test_wr_busy();
    int dc;
    for (int i = 0; i < NREGS; i++) regs[i] = {$urandom, $urandom};
    build_expected(5, 64'hDEAD);
    run_dump(0, 5, -1, -1, dc);
    vectors++;
    if (q_data.size() < 6 || q_data[5] !== 64'hDEAD) begin
      miscompares++;
      $display("FAIL wrbusy_beat5: got %h required dead", (q_data.size() >= 6) ? q_data[5] : '0);
    end
    vectors++;
    if (q_data !== e_data || q_idx !== e_idx || q_last !== e_last) begin
      miscompares++;
      $display("FAIL wrbusy_seq: beats=%0d required %0d", q_data.size(), e_data.size());
    end
    vectors++;
    if (dc !== 2 * NREGS + 1 + CS + 3) begin
      miscompares++;
      $display("FAIL wrbusy_done_cycle: got %0d required %0d", dc, 2 * NREGS + 4 + CS);
    end
  endtask

  task automatic test_restart_ignored();
    int dc;
    for (int i = 0; i < NREGS; i++) regs[i] = {$urandom, $urandom};
    build_expected(-1, '0);
    run_dump(0, -1, 10, -1, dc);
    vectors++;
    if (q_data !== e_data || q_idx !== e_idx || q_last !== e_last) begin
      miscompares++;
      $display("FAIL restart_seq: beats=%0d required %0d", q_data.size(), e_data.size());
    end
    vectors++;
    if (dc !== 2 * NREGS + 1 + CS) begin
      miscompares++;
      $display("FAIL restart_done_cycle: got %0d required %0d", dc, 2 * NREGS + 1 + CS);
    end
  endtask

  task automatic test_reset_mid();
    int dc;
    int done_seen;
    for (int i = 0; i < NREGS; i++) regs[i] = {$urandom, $urandom};
    run_dump(0, -1, -1, 10, dc);
    vectors++;
    if (q_data.size() !== 11) begin
      miscompares++;
      $display("FAIL rstmid_beats: got %0d beats before reset required 11", q_data.size());
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({ra, out_valid, out_data, out_idx, out_last, busy, done} !== '0) begin
      miscompares++;
      $display("FAIL rstmid_async: outputs=%h required 0", {ra, out_valid, out_data, out_idx, out_last, busy, done});
    end
    done_seen = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    vectors++;
    if (done_seen !== 0) begin
      miscompares++;
      $display("FAIL rstmid_no_done: saw %0d done pulses required 0", done_seen);
    end
    build_expected(-1, '0);
    run_dump(0, -1, -1, -1, dc);
    vectors++;
    if (q_data !== e_data || q_idx !== e_idx || q_last !== e_last) begin
      miscompares++;
      $display("FAIL rstmid_fresh_seq: beats=%0d first_idx=%0d required %0d beats from idx 0",
               q_data.size(), (q_idx.size() > 0) ? q_idx[0] : 5'd31, e_data.size());
    end
    vectors++;
    if (dc !== 2 * NREGS + 1 + CS) begin
      miscompares++;
      $display("FAIL rstmid_done_cycle: got %0d required %0d", dc, 2 * NREGS + 1 + CS);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ready_toggle();
    test_random();
    test_wr_busy();
    test_restart_ignored();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
